// File: rtl/overcooked_pkg.sv
// Shared types and sizes for the serving window: dish codes, per-space FSM
// states and the fixed player/space counts.
package overcooked_pkg;

  localparam int NUM_SPACES  = 2;
  localparam int NUM_PLAYERS = 2;
  localparam int DISH_W      = 4;

  typedef enum logic [DISH_W-1:0] {
    DISH_NONE        = 4'd0,
    DISH_ONION_SOUP  = 4'd1,
    DISH_TOMATO_SOUP = 4'd2,
    DISH_SALAD       = 4'd3,
    DISH_BURGER      = 4'd4,
    DISH_PASTA       = 4'd5
  } dish_t;

  typedef enum logic [1:0] {
    SPACE_EMPTY,
    SPACE_PRESENT,
    SPACE_CLEAR
  } space_state_t;

endpackage

// File: rtl/serve_window_if.sv
// Player drop, scorer and result signals of the serving window.
// master = players/scorer side, slave = serve_window.
interface serve_window_if
  import overcooked_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic [NUM_PLAYERS-1:0]             drop_req;
  logic [NUM_PLAYERS-1:0]             drop_space;
  logic [NUM_PLAYERS-1:0][DISH_W-1:0] drop_dish;
  logic [NUM_SPACES-1:0][DISH_W-1:0]  out_spaces;
  logic [NUM_SPACES-1:0][DISH_W-1:0]  check_spaces;
  logic [NUM_PLAYERS-1:0]             drop_ack;
  logic [NUM_PLAYERS-1:0]             drop_busy;
  logic [NUM_SPACES-1:0]              reject_pulse;
  logic [CNT_W-1:0]                   served_count;
  logic [CNT_W-1:0]                   rejected_count;

  modport master (
    output drop_req, drop_space, drop_dish, out_spaces,
    input  check_spaces, drop_ack, drop_busy, reject_pulse,
           served_count, rejected_count
  );

  modport slave (
    input  drop_req, drop_space, drop_dish, out_spaces,
    output check_spaces, drop_ack, drop_busy, reject_pulse,
           served_count, rejected_count
  );

endinterface

// File: rtl/serve_space.sv
// One serving space: EMPTY -> PRESENT -> CLEAR -> EMPTY.
// Timeout rejection and its wait counter exist only with SERVE_TIMEOUT_EN.
module serve_space
  import overcooked_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DISH_W-1:0] load_dish,
  input  logic [DISH_W-1:0] out_dish,
  output logic [DISH_W-1:0] check_dish,
  output logic              accepting,
  output logic              served,
  output logic              rejected
);

  space_state_t      state_q, state_d;
  logic [DISH_W-1:0] dish_q, dish_d;
  logic              timeout;

`ifdef SERVE_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q;

  // Held at zero outside PRESENT so every presentation starts counting from 0.
  always_ff @(posedge clock) begin
    if (reset || state_q != SPACE_PRESENT) wait_q <= '0;
    else                                   wait_q <= wait_q + 1'b1;
  end

  assign timeout = (wait_q == WAIT_LAST);
`else
  assign timeout = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SPACE_EMPTY;
      dish_q  <= DISH_NONE;
    end else begin
      state_q <= state_d;
      dish_q  <= dish_d;
    end
  end

  // NOTE: every output of this block is defaulted first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    dish_d   = dish_q;
    served   = 1'b0;
    rejected = 1'b0;
    unique case (state_q)
      SPACE_EMPTY: begin
        if (load) begin
          state_d = SPACE_PRESENT;
          dish_d  = load_dish;
        end
      end
      SPACE_PRESENT: begin
        // Consumption is checked first so it beats a simultaneous timeout.
        if (out_dish == DISH_NONE) begin
          served  = 1'b1;
          state_d = SPACE_CLEAR;
          dish_d  = DISH_NONE;
        end else if (timeout) begin
          rejected = 1'b1;
          state_d  = SPACE_CLEAR;
          dish_d   = DISH_NONE;
        end
      end
      SPACE_CLEAR: state_d = SPACE_EMPTY;
      default: begin
        state_d = SPACE_EMPTY;
        dish_d  = DISH_NONE;
      end
    endcase
  end

  assign check_dish = dish_q;
  assign accepting  = (state_q == SPACE_EMPTY);

endmodule

// File: rtl/serve_window.sv
// Serving window: two independent serving spaces, player arbitration and
// saturating served/rejected totals. Timeout rejection needs SERVE_TIMEOUT_EN.
module serve_window
  import overcooked_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 300,
  parameter int CNT_W          = 8
) (
  input logic           clock,
  input logic           reset,
  serve_window_if.slave bus
);

  logic [NUM_SPACES-1:0]             accepting, load, served_evt, reject_evt;
  logic [NUM_SPACES-1:0][DISH_W-1:0] load_dish, check_dish;
  logic [NUM_PLAYERS-1:0]            ack_d, busy_d, ack_q, busy_q;
  logic [NUM_SPACES-1:0]             reject_q;
  logic [CNT_W-1:0]                  served_q, rejected_q;
  logic [1:0]                        n_served, n_rejected;

  for (genvar s = 0; s < NUM_SPACES; s++) begin : g_space
    serve_space #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_space (
      .clock      (clock),
      .reset      (reset),
      .load       (load[s]),
      .load_dish  (load_dish[s]),
      .out_dish   (bus.out_spaces[s]),
      .check_dish (check_dish[s]),
      .accepting  (accepting[s]),
      .served     (served_evt[s]),
      .rejected   (reject_evt[s])
    );
  end

  // Players are scanned in index order, so player 0 claims a contested space.
  always_comb begin
    ack_d     = '0;
    busy_d    = '0;
    load      = '0;
    load_dish = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (bus.drop_req[p] && bus.drop_dish[p] != DISH_NONE) begin
        if (accepting[bus.drop_space[p]] && !load[bus.drop_space[p]]) begin
          load[bus.drop_space[p]]      = 1'b1;
          load_dish[bus.drop_space[p]] = bus.drop_dish[p];
          ack_d[p]                     = 1'b1;
        end else begin
          busy_d[p] = 1'b1;
        end
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + (CNT_W + 1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  assign n_served   = 2'($countones(served_evt));
  assign n_rejected = 2'($countones(reject_evt));

  // With the timeout disabled reject_evt is constant 0, so the reject pulse
  // and rejected_count reduce to constant zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_q      <= '0;
      busy_q     <= '0;
      reject_q   <= '0;
      served_q   <= '0;
      rejected_q <= '0;
    end else begin
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      reject_q   <= reject_evt;
      served_q   <= sat_add(served_q, n_served);
      rejected_q <= sat_add(rejected_q, n_rejected);
    end
  end

  assign bus.check_spaces   = check_dish;
  assign bus.drop_ack       = ack_q;
  assign bus.drop_busy      = busy_q;
  assign bus.reject_pulse   = reject_q;
  assign bus.served_count   = served_q;
  assign bus.rejected_count = rejected_q;

endmodule

// File: tb/tb_serve_window.sv
// Bench for serve_window: directed scenarios then random traffic, all checked
// against a behavioural model of the serving spaces. Honours SERVE_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_serve_window;
  import overcooked_pkg::*;

  localparam int TIMEOUT = 8;
`ifdef SERVE_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  serve_window_if #(.CNT_W(8)) bus ();
  serve_window_if #(.CNT_W(2)) bus_small ();

  serve_window #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  serve_window #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(2)) dut_small (
    .clock(clock), .reset(reset), .bus(bus_small)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: what each space holds, how long it has been shown, and whether it
  // is in its one-cycle cool-down after the dish leaves.
  int         m_held  [2];
  int         m_age   [2];
  bit         m_cool  [2];
  int         m_served;
  int         m_rejected;
  logic [1:0] m_ack, m_busy, m_rej;
  int         rej0_seen;

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_step(input bit rst, input logic [1:0] req, input logic [1:0] sp,
                            input logic [1:0][3:0] dish, input logic [1:0][3:0] outs);
    bit claimed [2];
    int new_dish [2];
    m_ack = '0; m_busy = '0; m_rej = '0;
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        m_held[s] = 0; m_age[s] = 0; m_cool[s] = 1'b0;
      end
      m_served = 0; m_rejected = 0;
      return;
    end
    claimed = '{1'b0, 1'b0};
    new_dish = '{0, 0};
    for (int p = 0; p < 2; p++) begin
      if (req[p] && dish[p] != 4'd0) begin
        int s;
        s = int'(sp[p]);
        if (m_held[s] == 0 && !m_cool[s] && !claimed[s]) begin
          claimed[s] = 1'b1; new_dish[s] = int'(dish[p]); m_ack[p] = 1'b1;
        end else begin
          m_busy[p] = 1'b1;
        end
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (m_held[s] != 0) begin
        if (outs[s] == 4'd0) begin
          m_served++; m_held[s] = 0; m_cool[s] = 1'b1;
        end else if (TIMEOUT_ON && m_age[s] + 1 == TIMEOUT) begin
          m_rejected++; m_rej[s] = 1'b1; m_held[s] = 0; m_cool[s] = 1'b1;
        end else begin
          m_age[s]++;
        end
      end else if (m_cool[s]) begin
        m_cool[s] = 1'b0;
      end else if (claimed[s]) begin
        m_held[s] = new_dish[s]; m_age[s] = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] exp_check;
    exp_check = {4'(m_held[1]), 4'(m_held[0])};
    check("check_spaces", 32'(bus.check_spaces), 32'(exp_check));
    check("drop_ack", 32'(bus.drop_ack), 32'(m_ack));
    check("drop_busy", 32'(bus.drop_busy), 32'(m_busy));
    check("reject_pulse", 32'(bus.reject_pulse), 32'(m_rej));
    check("served_count", 32'(bus.served_count), 32'(sat(m_served, 255)));
    check("rejected_count", 32'(bus.rejected_count), 32'(sat(m_rejected, 255)));
    check("served_count_w2", 32'(bus_small.served_count), 32'(sat(m_served, 3)));
    check("rejected_count_w2", 32'(bus_small.rejected_count), 32'(sat(m_rejected, 3)));
  endtask

  task automatic do_cycle(input bit rst, input logic [1:0] req, input logic [1:0] sp,
                          input logic [1:0][3:0] dish, input logic [1:0][3:0] outs);
    reset = rst;
    bus.drop_req = req;         bus_small.drop_req = req;
    bus.drop_space = sp;        bus_small.drop_space = sp;
    bus.drop_dish = dish;       bus_small.drop_dish = dish;
    bus.out_spaces = outs;      bus_small.out_spaces = outs;
    model_step(rst, req, sp, dish, outs);
    @(posedge clock);
    @(negedge clock);
    if (bus.reject_pulse[0] === 1'b1) rej0_seen++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.drop_req = '0; bus.drop_space = '0; bus.drop_dish = '0; bus.out_spaces = '0;
    bus_small.drop_req = '0; bus_small.drop_space = '0;
    bus_small.drop_dish = '0; bus_small.out_spaces = '0;
    @(negedge clock);
    do_cycle(1'b1, '0, '0, '0, '0);
    do_cycle(1'b1, '0, '0, '0, '0);
    idle(10);

    // Single dish on space 0, shown five cycles then consumed.
    do_cycle(1'b0, 2'b01, 2'b00, {4'd0, 4'd3}, '0);
    check("ack_first_drop", 32'(bus.drop_ack), 32'h1);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, '0, '0, '0, {4'd0, 4'd3});
    do_cycle(1'b0, '0, '0, '0, '0);
    check("served_after_one", 32'(bus.served_count), 32'd1);
    check("clear_empty_space0", 32'(bus.check_spaces[0]), 32'd0);
    do_cycle(1'b0, 2'b01, 2'b00, {4'd0, 4'd6}, {4'd0, 4'd6});
    check("busy_during_clear", 32'(bus.drop_busy), 32'h1);
    idle(1);

    // Contention on space 1: player 0 wins.
    do_cycle(1'b0, 2'b11, 2'b11, {4'd5, 4'd2}, '0);
    check("contend_ack", 32'(bus.drop_ack), 32'h1);
    check("contend_busy", 32'(bus.drop_busy), 32'h2);
    check("contend_space1", 32'(bus.check_spaces[1]), 32'd2);
    do_cycle(1'b0, 2'b10, 2'b10, {4'd7, 4'd0}, {4'd2, 4'd0});
    check("busy_present", 32'(bus.drop_busy), 32'h2);
    do_cycle(1'b0, '0, '0, '0, '0);
    idle(2);

    // Both spaces filled together and consumed in the same cycle.
    do_cycle(1'b0, 2'b11, 2'b10, {4'd2, 4'd1}, '0);
    check("split_ack", 32'(bus.drop_ack), 32'h3);
    do_cycle(1'b0, '0, '0, '0, '0);
    check("served_plus_two", 32'(bus.served_count), 32'd4);
    check("served_saturated_w2", 32'(bus_small.served_count), 32'd3);
    idle(2);

    // Never-consumed dish: rejected only when the timeout is built in.
    rej0_seen = 0;
    do_cycle(1'b0, 2'b01, 2'b00, {4'd0, 4'd4}, '0);
    for (int i = 0; i < 50; i++) do_cycle(1'b0, '0, '0, '0, {4'd0, 4'd4});
    check("timeout_reject_pulses", 32'(rej0_seen), TIMEOUT_ON ? 32'd1 : 32'd0);
    check("timeout_rejected_count", 32'(bus.rejected_count), TIMEOUT_ON ? 32'd1 : 32'd0);
    do_cycle(1'b0, '0, '0, '0, '0);
    idle(2);

    // Reset while a dish is presented.
    do_cycle(1'b0, 2'b01, 2'b00, {4'd0, 4'd1}, '0);
    do_cycle(1'b0, '0, '0, '0, {4'd0, 4'd1});
    do_cycle(1'b1, '0, '0, '0, {4'd0, 4'd1});
    check("reset_clears_spaces", 32'(bus.check_spaces), 32'd0);
    check("reset_clears_served", 32'(bus.served_count), 32'd0);
    check("reset_no_reject", 32'(bus.reject_pulse), 32'd0);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      logic [1:0] req, sp;
      logic [1:0][3:0] dish, outs;
      bit rst;
      rst = ($urandom_range(0, 99) == 0);
      req = 2'($urandom);
      sp  = 2'($urandom);
      for (int p = 0; p < 2; p++)
        dish[p] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      for (int s = 0; s < 2; s++)
        outs[s] = (m_held[s] != 0 && $urandom_range(0, 4) == 0) ? 4'd0
                                                                 : 4'($urandom_range(1, 15));
      do_cycle(rst, req, sp, dish, outs);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
